mtx_mvmul_seq: RTL and testbench

- Sequential ternary matrix × Q-format vector multiplier.
- Generalises the fixed 16×16 MVMUL datapath to parametrised rows, columns, precision and lanes-per-cycle.
- Adds saturation, status flags and valid/ready handshakes.
- Sits behind the VLIW decoder as the MVMUL execution unit: reads M0 and V0, writes the result to V1.

---
 rtl/mtx_mvmul_seq_pkg.sv | 70 +++++++
 rtl/mtx_mvmul_seq_mac_lane.sv | 26 ++
 rtl/mtx_mvmul_seq.sv | 168 ++++++++++++++++
 tb/tb_mtx_mvmul_seq.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtx_mvmul_seq_pkg.sv
// Shared types and arithmetic helpers for the ternary matrix x Q-format vector unit.
// Package mtx_types; the Q-format shape is set here by Q and INT.
package mtx_types;

   localparam int Q      = 23;
   localparam int INT    = 8;
   localparam int TOTAL  = INT + Q + 1;
   localparam int WIDE_W = 64;

   typedef enum logic [1:0] {
      ZERO  = 2'b00,
      PLUS  = 2'b01,
      MINUS = 2'b10,
      INVAL = 2'b11
   } val3_t;

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      SAT,
      DONE
   } mvmul_state_t;

   typedef logic signed [TOTAL-1:0]  qformat_t;
   typedef logic signed [TOTAL:0]    prod_t;
   typedef logic signed [WIDE_W-1:0] wide_t;

   typedef struct packed {
      logic of;
      logic uf;
      logic zero;
      logic inv;
   } status_t;

   typedef struct packed {
      qformat_t val;
      logic     of;
      logic     uf;
   } sat_t;

   localparam qformat_t QMAX = qformat_t'({1'b0, {(TOTAL-1){1'b1}}});
   localparam qformat_t QMIN = qformat_t'({1'b1, {(TOTAL-1){1'b0}}});

   // One guard bit keeps -QMIN representable.
   function automatic prod_t mul3_qformat(input val3_t m, input qformat_t x);
      prod_t xe;
      xe = prod_t'({x[TOTAL-1], x});
      case (m)
         PLUS:    return xe;
         MINUS:   return -xe;
         default: return '0;
      endcase
   endfunction

   function automatic sat_t sat_qformat(input wide_t acc);
      sat_t s;
      s.val = acc[TOTAL-1:0];
      s.of  = 1'b0;
      s.uf  = 1'b0;
      if (acc > wide_t'(QMAX)) begin
         s.val = QMAX;
         s.of  = 1'b1;
      end else if (acc < wide_t'(QMIN)) begin
         s.val = QMIN;
         s.uf  = 1'b1;
      end
      return s;
   endfunction

endpackage

// File: rtl/mtx_mvmul_seq_mac_lane.sv
// One matrix row: LANES ternary products of the current column group summed together,
// with detection of the invalid 2'b11 code.
module mtx_mac_lane
   import mtx_types::*;
#(
   parameter int LANES = 4,
   parameter int SUM_W = TOTAL + 1 + $clog2(LANES)
) (
   input  logic [LANES*2-1:0]     m,
   input  logic [LANES*TOTAL-1:0] x,
   output logic signed [SUM_W-1:0] sum,
   output logic                    inv
);

   // NOTE: combinational logic uses blocking '=' and assigns a default to every
   // output first, so no path leaves a value held and no latch is inferred.
   always_comb begin
      sum = '0;
      inv = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         sum = sum + SUM_W'(mul3_qformat(val3_t'(m[l*2 +: 2]), qformat_t'(x[l*TOTAL +: TOTAL])));
         inv = inv | (m[l*2 +: 2] == INVAL);
      end
   end

endmodule

// File: rtl/mtx_mvmul_seq.sv
// Sequential ternary matrix x Q-format vector multiplier with saturation and valid/ready.
// Optional MTX_MVMUL_RELU_EN adds relu_en, clamping negative results to zero.
module mtx_mvmul_seq #(
   parameter int Q     = mtx_types::Q,
   parameter int INT   = mtx_types::INT,
   parameter int R     = 16,
   parameter int C     = 16,
   parameter int LANES = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
`ifdef MTX_MVMUL_RELU_EN
   input  logic                     relu_en,
`endif
   input  logic                     start_valid,
   output logic                     start_ready,
   input  logic [R*C*2-1:0]         mtx_in,
   input  logic [C*(INT+Q+1)-1:0]   vec_in,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [R*(INT+Q+1)-1:0]   res_out,
   output logic [3:0]               status_out,
   output logic                     busy
);

   import mtx_types::*;

   localparam int TOT   = INT + Q + 1;
   localparam int ACC_W = TOT + $clog2(C) + 1;
   localparam int SUM_W = TOT + 1 + $clog2(LANES);
   localparam int STEPS = C / LANES;
   localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   if (C % LANES != 0) begin : g_bad_lanes
      $error("mtx_mvmul_seq: C must be a multiple of LANES");
   end
   if (TOT != TOTAL) begin : g_bad_qformat
      $error("mtx_mvmul_seq: Q/INT must match the mtx_types qformat_t shape");
   end
   if (ACC_W > WIDE_W) begin : g_bad_acc
      $error("mtx_mvmul_seq: accumulator wider than the saturation input");
   end

   mvmul_state_t state;
   logic [SW-1:0] step;
   logic          inv_q;
   logic          accept;

   logic [R*C*2-1:0] mtx_q;
   logic [C*TOT-1:0] vec_q;

   logic signed [ACC_W-1:0] acc      [R];
   logic signed [SUM_W-1:0] lane_sum [R];
   logic [R-1:0]            lane_inv;

   sat_t          sat_r [R];
   logic [R*TOT-1:0] sat_vec;
   status_t       sat_st;

`ifdef MTX_MVMUL_RELU_EN
   logic relu_q;
`endif

   assign start_ready = (state == IDLE) || (state == DONE && res_ready);
   assign accept      = start_valid && start_ready;
   assign busy        = (state != IDLE);

   // NOTE: operand latches carry no reset; they are only read after an accept
   // has loaded them, and leaving them out of the async-reset block avoids
   // spreading reset fanout over R*C*2 + C*TOT flops.
   always_ff @(posedge clk) begin
      if (accept) begin
         mtx_q <= mtx_in;
         vec_q <= vec_in;
      end
   end

   for (genvar r = 0; r < R; r++) begin : g_row
      mtx_mac_lane #(
         .LANES (LANES),
         .SUM_W (SUM_W)
      ) u_lane (
         .m   (mtx_q[(r*C + int'(step)*LANES)*2 +: LANES*2]),
         .x   (vec_q[int'(step)*LANES*TOT +: LANES*TOT]),
         .sum (lane_sum[r]),
         .inv (lane_inv[r])
      );
   end

   always_comb begin
      sat_vec = '0;
      sat_st  = '0;
      for (int r = 0; r < R; r++) begin
         sat_r[r]  = sat_qformat(wide_t'(acc[r]));
         sat_st.of = sat_st.of | sat_r[r].of;
         sat_st.uf = sat_st.uf | sat_r[r].uf;
         sat_vec[r*TOT +: TOT] = sat_r[r].val;
`ifdef MTX_MVMUL_RELU_EN
         if (relu_q && sat_r[r].val[TOT-1]) begin
            sat_vec[r*TOT +: TOT] = '0;
         end
`endif
      end
      // zero is judged on the value actually presented, after any clamp.
      sat_st.zero = (sat_vec == '0);
      sat_st.inv  = inv_q;
   end

   // NOTE: all state below updates with non-blocking '<=' so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         step       <= '0;
         inv_q      <= 1'b0;
         res_valid  <= 1'b0;
         res_out    <= '0;
         status_out <= '0;
         for (int r = 0; r < R; r++) begin
            acc[r] <= '0;
         end
`ifdef MTX_MVMUL_RELU_EN
         relu_q     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (state == DONE && res_ready) begin
                  res_valid <= 1'b0;
               end
               if (accept) begin
                  state      <= ACC;
                  step       <= '0;
                  inv_q      <= 1'b0;
                  status_out <= '0;
                  for (int r = 0; r < R; r++) begin
                     acc[r] <= '0;
                  end
`ifdef MTX_MVMUL_RELU_EN
                  relu_q     <= relu_en;
`endif
               end else if (state == DONE && res_ready) begin
                  state <= IDLE;
               end
            end
            ACC: begin
               for (int r = 0; r < R; r++) begin
                  acc[r] <= acc[r] + ACC_W'(lane_sum[r]);
               end
               inv_q <= inv_q | (|lane_inv);
               if (step == SW'(STEPS - 1)) begin
                  state <= SAT;
               end else begin
                  step <= step + 1'b1;
               end
            end
            SAT: begin
               res_out    <= sat_vec;
               status_out <= sat_st;
               res_valid  <= 1'b1;
               state      <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mtx_mvmul_seq.sv
// Self-checking bench for mtx_mvmul_seq: directed and random operations against
// an integer-arithmetic reference of the matrix-vector product with saturation.
module tb_mtx_mvmul_seq;

   localparam int R   = 16;
   localparam int C   = 16;
   localparam int TOT = 32;
   localparam logic [31:0] ONE = 32'h0080_0000;
   localparam longint QMAX_L = 64'sd2147483647;
   localparam longint QMIN_L = -64'sd2147483648;

   logic clk = 1'b0;
   logic rst_n;
   logic start_valid, start_ready;
   logic [R*C*2-1:0] mtx_in;
   logic [C*TOT-1:0] vec_in;
   logic res_valid, res_ready;
   logic [R*TOT-1:0] res_out;
   logic [3:0] status_out;
   logic busy;

   logic [1:0]  m [R][C];
   logic [31:0] v [C];
   logic [31:0] exp_res [R];
   logic [3:0]  exp_st;

   int n_vec = 0;
   int n_err = 0;

   mtx_mvmul_seq dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .mtx_in      (mtx_in),
      .vec_in      (vec_in),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_out     (res_out),
      .status_out  (status_out),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic load_inputs();
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++)
            mtx_in[(r*C+c)*2 +: 2] = m[r][c];
      for (int c = 0; c < C; c++)
         vec_in[c*TOT +: TOT] = v[c];
   endtask

   // Reference: exact integer dot products, then clamp to the 32-bit signed range.
   task automatic model();
      logic of, uf, inv, allz;
      longint s;
      of = 0; uf = 0; inv = 0; allz = 1;
      for (int r = 0; r < R; r++) begin
         s = 0;
         for (int c = 0; c < C; c++) begin
            case (m[r][c])
               2'b01:   s = s + longint'($signed(v[c]));
               2'b10:   s = s - longint'($signed(v[c]));
               2'b11:   inv = 1;
               default: ;
            endcase
         end
         if (s > QMAX_L) begin
            exp_res[r] = 32'h7FFF_FFFF; of = 1;
         end else if (s < QMIN_L) begin
            exp_res[r] = 32'h8000_0000; uf = 1;
         end else begin
            exp_res[r] = s[31:0];
         end
         if (exp_res[r] != 32'h0) allz = 0;
      end
      exp_st = {of, uf, allz, inv};
   endtask

   task automatic fill(input logic [1:0] code, input logic [31:0] val);
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++)
            m[r][c] = code;
      for (int c = 0; c < C; c++)
         v[c] = val;
   endtask

   task automatic rand_op(input int mode);
      logic [31:0] t;
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++)
            m[r][c] = 2'($urandom_range(0, 3));
      for (int c = 0; c < C; c++) begin
         if (mode == 0) begin
            v[c] = $urandom;
         end else begin
            t = $urandom_range(0, 32'h0100_0000);
            v[c] = ($urandom_range(0, 1) == 1) ? (~t + 32'd1) : t;
         end
      end
   endtask

   task automatic start_op();
      int guard;
      load_inputs();
      start_valid = 1'b1;
      guard = 0;
      while (!start_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      check("start_ready before accept", 64'(start_ready), 64'd1);
      @(posedge clk); #1;
      start_valid = 1'b0;
   endtask

   task automatic wait_result(input string tag);
      int lat;
      lat = 0;
      while (!res_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'd5);
   endtask

   task automatic check_result(input string tag);
      for (int r = 0; r < R; r++)
         check($sformatf("%s res[%0d]", tag, r), 64'(res_out[r*TOT +: TOT]), 64'(exp_res[r]));
      check({tag, " status"}, 64'(status_out), 64'(exp_st));
   endtask

   task automatic retire(input string tag);
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      check({tag, " res_valid after retire"}, 64'(res_valid), 64'd0);
      check({tag, " busy after retire"}, 64'(busy), 64'd0);
   endtask

   task automatic run(input string tag);
      model();
      start_op();
      wait_result(tag);
      check_result(tag);
      retire(tag);
   endtask

   initial begin
      rst_n = 1'b0;
      start_valid = 1'b0;
      res_ready = 1'b0;
      mtx_in = '0;
      vec_in = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset res_valid", 64'(res_valid), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset res_out", 64'(res_out == '0), 64'd1);
      check("reset status", 64'(status_out), 64'd0);
      check("reset start_ready", 64'(start_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Diagonal PLUS, v[i] = i * 1.0.
      fill(2'b00, 32'h0);
      for (int i = 0; i < R; i++) begin
         m[i][i] = 2'b01;
         v[i] = ONE * i;
      end
      run("diag");
      check("diag res[7] literal", 64'(res_out[7*TOT +: TOT]), 64'h0380_0000);

      fill(2'b01, 32'h3200_0000);
      model();
      start_op();
      wait_result("allplus");
      check_result("allplus");
      check("allplus res[0] literal", 64'(res_out[31:0]), 64'h7FFF_FFFF);
      check("allplus of/uf", 64'(status_out[3:2]), 64'b10);
      retire("allplus");

      fill(2'b10, 32'h3200_0000);
      model();
      start_op();
      wait_result("allminus");
      check_result("allminus");
      check("allminus res[15] literal", 64'(res_out[15*TOT +: TOT]), 64'h8000_0000);
      check("allminus of/uf", 64'(status_out[3:2]), 64'b01);
      retire("allminus");

      // -min must saturate rather than wrap.
      fill(2'b00, 32'h0);
      m[0][0] = 2'b10;
      v[0] = 32'h8000_0000;
      model();
      start_op();
      wait_result("negmin");
      check_result("negmin");
      check("negmin res[0] literal", 64'(res_out[31:0]), 64'h7FFF_FFFF);
      retire("negmin");

      fill(2'b00, 32'h0);
      for (int c = 0; c < C; c++) v[c] = $urandom;
      run("zero");
      check("zero flag literal", 64'(exp_st), 64'b0010);

      fill(2'b00, ONE);
      for (int i = 0; i < R; i++) m[i][i] = 2'b01;
      m[3][5] = 2'b11;
      model();
      start_op();
      wait_result("inval");
      check_result("inval");
      check("inval res[3] literal", 64'(res_out[3*TOT +: TOT]), 64'(ONE));
      check("inval inv bit", 64'(status_out[0]), 64'd1);
      retire("inval");

      for (int k = 0; k < 6; k++) begin
         rand_op(k % 2);
         run($sformatf("rand%0d", k));
      end

      // Backpressure, then retire and accept in the same edge.
      rand_op(1);
      model();
      start_op();
      wait_result("bp1");
      check_result("bp1");
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("bp hold res[0]", 64'(res_out[31:0]), 64'(exp_res[0]));
         check("bp hold res[15]", 64'(res_out[15*TOT +: TOT]), 64'(exp_res[15]));
         check("bp hold status", 64'(status_out), 64'(exp_st));
         check("bp start_ready low", 64'(start_ready), 64'd0);
         check("bp res_valid high", 64'(res_valid), 64'd1);
      end
      rand_op(1);
      model();
      load_inputs();
      start_valid = 1'b1;
      res_ready = 1'b1;
      #1;
      check("b2b start_ready", 64'(start_ready), 64'd1);
      @(posedge clk); #1;
      start_valid = 1'b0;
      res_ready = 1'b0;
      check("b2b res_valid dropped", 64'(res_valid), 64'd0);
      check("b2b busy", 64'(busy), 64'd1);
      wait_result("bp2");
      check_result("bp2");
      retire("bp2");

      // Reset during the second ACC cycle aborts the operation.
      rand_op(0);
      model();
      start_op();
      @(posedge clk); #3;
      check("pre-abort busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("abort res_valid", 64'(res_valid), 64'd0);
      check("abort busy", 64'(busy), 64'd0);
      check("abort res_out", 64'(res_out == '0), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
         check("post-abort idle res_valid", 64'(res_valid), 64'd0);
      end
      rand_op(1);
      run("after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
